// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter. It generates the PS/2 clock itself and sends
// one byte per frame (start, 8 data bits LSB first, odd parity, stop) over
// open-drain lines. If the host inhibits the link by holding the clock low,
// the frame is abandoned and sent again once the bus has been idle long enough.
module ps2_device_tx #(
  parameter int CLK_HALF = 1750,  // qzt_clk cycles per PS/2 clock half-period
  parameter int IDLE_MIN = 2500   // idle cycles required before a frame starts
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  inout  wire        PS2C,
  inout  wire        PS2D
);

  localparam int CNT_MAX = (CLK_HALF > IDLE_MIN) ? CLK_HALF : IDLE_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_HIGH,
    S_LOW,
    S_END,
    S_ABORT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [10:0]      frame, frame_n;   // {stop, parity, data[7:0], start}
  logic [1:0]       c_sync, d_sync;
  logic             drive_c, drive_d;
  logic             c_s, d_s;

  assign c_s = c_sync[1];
  assign d_s = d_sync[1];

  // Open drain: a line is either pulled to 0 or released, never driven to 1.
  assign PS2C = drive_c ? 1'b0 : 1'bz;
  assign PS2D = drive_d ? 1'b0 : 1'bz;

  // Two-flop synchronizers for the externally driven bus lines.
  always_ff @(posedge qzt_clk) begin
    // NOTE: the synchronizers reset to the released (high) level so a reset
    // never looks like a host inhibit; state uses non-blocking assignments so
    // every flop samples the pre-edge values.
    if (reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], PS2C};
      d_sync <= {d_sync[0], PS2D};
    end
  end

  // State, counters and the latched frame.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      frame <= frame_n;
    end
  end

  // Next-state logic, line drive and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    frame_n  = frame;
    drive_c  = 1'b0;
    drive_d  = 1'b0;
    tx_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    aborted  = 1'b0;

    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          frame_n = {1'b1, ~^tx_data, tx_data, 1'b0};
          cnt_n   = '0;
          state_n = S_WAIT_BUS;
        end
      end

      // Both lines must read high for IDLE_MIN consecutive cycles.
      S_WAIT_BUS: begin
        if (c_s && d_s) begin
          if (cnt == CNT_W'(IDLE_MIN - 1)) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = S_HIGH;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
      end

      // Clock released, data set up; a low clock at the end is the host.
      S_HIGH: begin
        drive_d = ~frame[idx];
        if (cnt == CNT_W'(CLK_HALF - 1)) begin
          cnt_n   = '0;
          state_n = c_s ? S_LOW : S_ABORT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Clock pulled low; the host samples data on this falling edge.
      S_LOW: begin
        drive_c = 1'b1;
        drive_d = ~frame[idx];
        if (cnt == CNT_W'(CLK_HALF - 1)) begin
          cnt_n   = '0;
          idx_n   = idx + 4'd1;
          state_n = (idx == 4'd10) ? S_END : S_HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_END: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      // Keep the latched frame and retry from the start bit.
      S_ABORT: begin
        aborted = 1'b1;
        cnt_n   = '0;
        state_n = S_WAIT_BUS;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
